// File: rtl/mem_access_sequencer_if.sv
// Pipeline-side and D-cache-side signals of the MEM-stage access sequencer.
// The slave modport is the sequencer; the master modport is the pipeline/cache environment.
interface mem_access_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  iValid;
   logic                  iMemRead;
   logic                  iMemWrite;
   logic                  iIndirect;
   logic                  iByteEnable;
   logic [ADDR_WIDTH-1:0] iAddr;
   logic [DATA_WIDTH-1:0] iStoreData;
   logic                  iPipeHold;
   logic                  oDcacheRead;
   logic                  oDcacheWrite;
   logic [ADDR_WIDTH-1:0] oDcacheAddr;
   logic [DATA_WIDTH-1:0] oDcacheWdata;
   logic [1:0]            oDcacheByteEn;
   logic                  iDcacheResp;
   logic [DATA_WIDTH-1:0] iDcacheRdata;
   logic                  oStall;
   logic [DATA_WIDTH-1:0] oLoadData;
   logic                  oDone;

   modport master (
      output iValid, iMemRead, iMemWrite, iIndirect, iByteEnable, iAddr, iStoreData,
             iPipeHold, iDcacheResp, iDcacheRdata,
      input  oDcacheRead, oDcacheWrite, oDcacheAddr, oDcacheWdata, oDcacheByteEn,
             oStall, oLoadData, oDone
   );

   modport slave (
      input  iValid, iMemRead, iMemWrite, iIndirect, iByteEnable, iAddr, iStoreData,
             iPipeHold, iDcacheResp, iDcacheRdata,
      output oDcacheRead, oDcacheWrite, oDcacheAddr, oDcacheWdata, oDcacheByteEn,
             oStall, oLoadData, oDone
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// LC-3b MEM-stage controller: one D-cache access (LDR/STR/LDB/STB) or pointer fetch plus
// access (LDI/STI); stalls until the response, formats load data, parks it during iPipeHold.
module mem_access_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_access_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PTR, ACC, HOLD} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

   logic                  memop;
   logic                  acc_read;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [DATA_WIDTH-1:0] fmt_data;

   always_comb begin
      memop    = bus.iValid & (bus.iMemRead | bus.iMemWrite);
      // Write wins when both read and write are decoded.
      acc_read = bus.iMemRead & ~bus.iMemWrite;
      eff_addr = bus.iIndirect ? ptr_q : acc_addr_q;

      if (!bus.iByteEnable)
         fmt_data = bus.iDcacheRdata;
      else if (eff_addr[0])
         fmt_data = {{(DATA_WIDTH-8){1'b0}}, bus.iDcacheRdata[15:8]};
      else
         fmt_data = {{(DATA_WIDTH-8){1'b0}}, bus.iDcacheRdata[7:0]};

      state_d           = state_q;
      ptr_d             = ptr_q;
      acc_addr_d        = acc_addr_q;
      hold_data_d       = hold_data_q;
      bus.oDcacheRead   = 1'b0;
      bus.oDcacheWrite  = 1'b0;
      bus.oDcacheAddr   = '0;
      bus.oDcacheWdata  = '0;
      bus.oDcacheByteEn = 2'b00;
      bus.oStall        = 1'b0;
      bus.oLoadData     = '0;
      bus.oDone         = 1'b0;

      case (state_q)
         IDLE: begin
            bus.oStall = memop;
            if (memop) begin
               if (bus.iIndirect) begin
                  state_d = PTR;
               end else begin
                  state_d    = ACC;
                  acc_addr_d = bus.iAddr;
               end
            end
         end
         PTR: begin
            bus.oDcacheRead   = 1'b1;
            bus.oDcacheAddr   = {bus.iAddr[ADDR_WIDTH-1:1], 1'b0};
            bus.oDcacheByteEn = 2'b11;
            bus.oStall        = 1'b1;
            if (bus.iDcacheResp) begin
               ptr_d      = bus.iDcacheRdata[ADDR_WIDTH-1:0];
               acc_addr_d = bus.iDcacheRdata[ADDR_WIDTH-1:0];
               state_d    = ACC;
            end
         end
         ACC: begin
            bus.oDcacheRead  = acc_read;
            bus.oDcacheWrite = ~acc_read;
            if (bus.iByteEnable) begin
               bus.oDcacheAddr   = eff_addr;
               bus.oDcacheByteEn = eff_addr[0] ? 2'b10 : 2'b01;
               bus.oDcacheWdata  = {bus.iStoreData[7:0], bus.iStoreData[7:0]};
            end else begin
               bus.oDcacheAddr   = {eff_addr[ADDR_WIDTH-1:1], 1'b0};
               bus.oDcacheByteEn = 2'b11;
               bus.oDcacheWdata  = bus.iStoreData;
            end
            bus.oStall = ~bus.iDcacheResp;
            if (bus.iDcacheResp) begin
               bus.oDone     = 1'b1;
               bus.oLoadData = fmt_data;
               // Park the result so the instruction is never re-issued while frozen downstream.
               if (bus.iPipeHold) begin
                  hold_data_d = fmt_data;
                  state_d     = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            bus.oLoadData = hold_data_q;
            if (!bus.iPipeHold)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         acc_addr_q  <= '0;
         hold_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         acc_addr_q  <= acc_addr_d;
         hold_data_q <= hold_data_d;
      end
   end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer.
module tb_mem_access_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   mem_access_sequencer_if bus ();

   mem_access_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic rd, input logic wr,
                          input logic st, input logic dn);
      chk({tag, ".rd"},    16'(bus.oDcacheRead),  16'(rd));
      chk({tag, ".wr"},    16'(bus.oDcacheWrite), 16'(wr));
      chk({tag, ".stall"}, 16'(bus.oStall),       16'(st));
      chk({tag, ".done"},  16'(bus.oDone),        16'(dn));
   endtask

   task automatic exp_req(input string tag, input logic [15:0] addr, input logic [1:0] be);
      chk({tag, ".addr"}, bus.oDcacheAddr, addr);
      chk({tag, ".be"},   16'(bus.oDcacheByteEn), 16'(be));
   endtask

   task automatic drv(input logic v, input logic r, input logic w, input logic ind,
                      input logic bt, input logic [15:0] a, input logic [15:0] sd);
      bus.iValid      = v;
      bus.iMemRead    = r;
      bus.iMemWrite   = w;
      bus.iIndirect   = ind;
      bus.iByteEnable = bt;
      bus.iAddr       = a;
      bus.iStoreData  = sd;
   endtask

   task automatic rsp(input logic r, input logic [15:0] d);
      bus.iDcacheResp  = r;
      bus.iDcacheRdata = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      rsp(0, 16'h0000);
      bus.iPipeHold = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sample();
      exp_out("reset", 0, 0, 0, 0);
      exp_req("reset", 16'h0000, 2'b00);
      chk("reset.wdata", bus.oDcacheWdata, 16'h0000);
      chk("reset.ld", bus.oLoadData, 16'h0000);

      // Non-memory op passes straight through
      next_cycle(); drv(1, 0, 0, 0, 0, 16'h1234, 16'h0000);
      sample(); exp_out("nonmem", 0, 0, 0, 0);

      // LDR 0x1235, response on the fourth ACC cycle
      next_cycle(); drv(1, 1, 0, 0, 0, 16'h1235, 16'h0000);
      sample(); exp_out("ldr.c0", 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         sample(); exp_out("ldr.wait", 1, 0, 1, 0); exp_req("ldr.wait", 16'h1234, 2'b11);
      end
      next_cycle(); rsp(1, 16'hBEEF);
      sample(); exp_out("ldr.resp", 1, 0, 0, 1); chk("ldr.ld", bus.oLoadData, 16'hBEEF);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("ldr.idle", 0, 0, 0, 0); chk("ldr.idle.ld", bus.oLoadData, 16'h0000);

      // LDB high byte then low byte, immediate responses, back to back
      next_cycle(); drv(1, 1, 0, 0, 1, 16'h2001, 16'h0000);
      sample(); exp_out("ldb1.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'hA55A);
      sample(); exp_out("ldb1.resp", 1, 0, 0, 1); exp_req("ldb1", 16'h2001, 2'b10);
      chk("ldb1.ld", bus.oLoadData, 16'h00A5);
      next_cycle(); rsp(0, 16'h0000); drv(1, 1, 0, 0, 1, 16'h2000, 16'h0000);
      sample(); exp_out("ldb0.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'hA55A);
      sample(); exp_out("ldb0.resp", 1, 0, 0, 1); exp_req("ldb0", 16'h2000, 2'b01);
      chk("ldb0.ld", bus.oLoadData, 16'h005A);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("ldb0.idle", 0, 0, 0, 0);

      // STB 0x3001
      next_cycle(); drv(1, 0, 1, 0, 1, 16'h3001, 16'h1277);
      sample(); exp_out("stb.c0", 0, 0, 1, 0);
      next_cycle();
      sample(); exp_out("stb.wait", 0, 1, 1, 0); exp_req("stb", 16'h3001, 2'b10);
      chk("stb.wdata", bus.oDcacheWdata, 16'h7777);
      next_cycle(); rsp(1, 16'h0000);
      sample(); exp_out("stb.resp", 0, 1, 0, 1);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("stb.idle", 0, 0, 0, 0);

      // LDI 0x4000 -> pointer 0x5002 -> 0x1111
      next_cycle(); drv(1, 1, 0, 1, 0, 16'h4000, 16'h0000);
      sample(); exp_out("ldi.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'h5002);
      sample(); exp_out("ldi.ptr", 1, 0, 1, 0); exp_req("ldi.ptr", 16'h4000, 2'b11);
      next_cycle(); rsp(1, 16'h1111);
      sample(); exp_out("ldi.acc", 1, 0, 0, 1); exp_req("ldi.acc", 16'h5002, 2'b11);
      chk("ldi.ld", bus.oLoadData, 16'h1111);

      // STI through the same pointer
      next_cycle(); rsp(0, 16'h0000); drv(1, 0, 1, 1, 0, 16'h4000, 16'hABCD);
      sample(); exp_out("sti.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'h5002);
      sample(); exp_out("sti.ptr", 1, 0, 1, 0); exp_req("sti.ptr", 16'h4000, 2'b11);
      next_cycle(); rsp(1, 16'h0000);
      sample(); exp_out("sti.acc", 0, 1, 0, 1); exp_req("sti.acc", 16'h5002, 2'b11);
      chk("sti.wdata", bus.oDcacheWdata, 16'hABCD);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("sti.idle", 0, 0, 0, 0);

      // Read and write both set: write wins
      next_cycle(); drv(1, 1, 1, 0, 0, 16'h8002, 16'h5555);
      sample(); exp_out("rw.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'h0000);
      sample(); exp_out("rw.resp", 0, 1, 0, 1); exp_req("rw", 16'h8002, 2'b11);
      chk("rw.wdata", bus.oDcacheWdata, 16'h5555);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("rw.idle", 0, 0, 0, 0);

      // LDR completing under a 3-cycle downstream hold
      next_cycle(); drv(1, 1, 0, 0, 0, 16'h6000, 16'h0000);
      sample(); exp_out("hold.c0", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'hCAFE); bus.iPipeHold = 1'b1;
      sample(); exp_out("hold.resp", 1, 0, 0, 1); chk("hold.resp.ld", bus.oLoadData, 16'hCAFE);
      for (int i = 0; i < 2; i++) begin
         next_cycle(); rsp(0, 16'h0000);
         sample(); exp_out("hold.held", 0, 0, 0, 0); chk("hold.held.ld", bus.oLoadData, 16'hCAFE);
      end
      next_cycle(); bus.iPipeHold = 1'b0;
      sample(); exp_out("hold.rel", 0, 0, 0, 0); chk("hold.rel.ld", bus.oLoadData, 16'hCAFE);
      next_cycle(); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("hold.idle", 0, 0, 0, 0); chk("hold.idle.ld", bus.oLoadData, 16'h0000);

      // Reset while the pointer fetch is outstanding
      next_cycle(); drv(1, 1, 0, 1, 0, 16'h7000, 16'h0000);
      sample(); exp_out("rst.c0", 0, 0, 1, 0);
      next_cycle(); reset = 1'b1;
      sample(); exp_out("rst.ptr", 1, 0, 1, 0); exp_req("rst.ptr", 16'h7000, 2'b11);
      next_cycle(); reset = 1'b0; drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000); rsp(1, 16'hDEAD);
      sample(); exp_out("rst.after", 0, 0, 0, 0); chk("rst.after.ld", bus.oLoadData, 16'h0000);
      next_cycle(); rsp(0, 16'h0000); drv(1, 1, 0, 0, 0, 16'h0010, 16'h0000);
      sample(); exp_out("rst.memop", 0, 0, 1, 0);
      next_cycle(); rsp(1, 16'h0042);
      sample(); exp_out("rst.ldr", 1, 0, 0, 1); exp_req("rst.ldr", 16'h0010, 2'b11);
      chk("rst.ldr.ld", bus.oLoadData, 16'h0042);
      next_cycle(); rsp(0, 16'h0000); drv(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
      sample(); exp_out("final.idle", 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
